emission_sweep_ctrl: RTL and testbench
======================================

// Module: emission_sweep_ctrl
// PURPOSE
//  Sequencer in front of the emission-probability lookup table. Accepts one word index per
//  observation step and sweeps every POS tag 0..POS_NUM-1 through the table.
//  Streams (pos, emission probability) beats to the Viterbi trellis update with valid/ready and a
//  last flag. The table read is combinational; this block owns all table addressing.
// PARAMETERS
//  WORD_NUM_BIT  8   width of word index
//  POS_NUM_BIT   4   width of POS index
//  POS_NUM       11  number of POS tags swept per word (>=1, <=2**POS_NUM_BIT)
//  P_SIZE        32  width of a probability word
//  MAX_WORD      95  number of valid word entries in the table
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             synchronous, active-high reset
//  word_in     in   WORD_NUM_BIT  word index of next observation
//  word_valid  in   1             word_in valid
//  word_ready  out  1             controller can accept a word
//  tbl_word    out  WORD_NUM_BIT  table address: word
//  tbl_pos     out  POS_NUM_BIT   table address: POS
//  tbl_p       in   P_SIZE        table data for (tbl_word, tbl_pos), same cycle
//  out_pos     out  POS_NUM_BIT   POS of current beat
//  out_p       out  P_SIZE        emission probability of current beat
//  out_valid   out  1             beat valid
//  out_ready   in   1             downstream accepts beat
//  out_last    out  1             beat is POS_NUM-1 of this word
//  busy        out  1             sweep in progress (state != IDLE)
//  err         out  1             (EMISS_RANGE_CHECK_EN only) 1-cycle pulse, word rejected
// BEHAVIOUR
//  - Reset: state=IDLE, word_ready=1, out_valid=0, out_last=0, out_pos=0, out_p=0,
//    tbl_word=0, tbl_pos=0, busy=0, err=0. Reset mid-sweep aborts; partial beats are discarded.
//  - FSM: IDLE -> SWEEP on word_valid&word_ready; SWEEP -> DRAIN when beat POS_NUM-1 is loaded
//    into the output register; DRAIN -> IDLE when that beat handshakes (out_valid&out_ready).
//  - word_ready = (state==IDLE). Word latched into tbl_word on accept; tbl_pos cleared to 0.
//  - SWEEP: output register loads {tbl_pos, tbl_p} when empty or being drained this cycle
//    (load = !out_valid | out_ready); on load tbl_pos increments. Full throughput = 1 beat/clk.
//  - Latency: first beat out_valid in cycle N+2 after the accept edge N+1 (one cycle to address,
//    one to register); a POS_NUM-beat word takes POS_NUM+1 cycles under continuous out_ready.
//  - Backpressure: out_valid held, out_pos/out_p/out_last stable while out_ready=0; tbl_pos is
//    not advanced, so no beat is lost or duplicated.
//  - out_last=1 only with out_pos==POS_NUM-1. tbl_pos never exceeds POS_NUM-1 (no wrap).
//  - Back-to-back words: next word accepted the cycle after the last beat handshakes (1 bubble).
//  - word_valid while busy: ignored (held by producer per valid/ready rules).
// CONFIGURATION
//  - EMISS_RANGE_CHECK_EN defined: word_in >= MAX_WORD at accept is consumed (word_ready=1),
//    err pulses 1 cycle, no sweep started, state stays IDLE.
//  - Not defined: no check, err port absent; out-of-range words swept as-is (table contents
//    undefined).
// STRUCTURE
//  - Shared package viterbi_pkg: WORD_NUM_BIT, POS_NUM_BIT, POS_NUM, P_SIZE, MAX_WORD
//    constants; sweep state enum {IDLE, SWEEP, DRAIN}.
//  - One sub-module: emission_out_reg (valid/ready output holding register, load/hold logic).
//  - FSM, POS counter and word latch stay in the top module.
// TESTING
//  - Reset then word 5, out_ready=1 -> 11 beats pos 0..10, out_p = table[pos][5],
//    out_last only on pos 10, word_ready returns 1 one cycle after last beat.
//  - out_ready toggled 1,0,0,1 during word 7 -> each beat held stable while stalled;
//    exactly 11 unique beats.
//  - Two words 3 then 9 presented back-to-back -> 22 beats, single bubble between words,
//    second word's beats start pos 0.
//  - rst asserted at beat pos 4 -> next cycle out_valid=0, word_ready=1, tbl_pos=0;
//    next word sweeps from pos 0.
//  - EMISS_RANGE_CHECK_EN: word 95 -> err=1 for one cycle, no out_valid; word 94 -> normal sweep.
//  - word_valid held high during sweep with different word_in -> ignored until IDLE.

Source files
------------

// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
//   Shared constants and types for the Viterbi decoder front end.
//   WORD_NUM_BIT / POS_NUM_BIT : widths of the word and POS indices
//   POS_NUM                    : number of POS tags swept per observed word
//   P_SIZE                     : width of a probability word
//   MAX_WORD                   : number of valid word entries in the emission table
//   sweep_state_e              : emission sweep sequencer states
// -----------------------------------------------------------------------------
package viterbi_pkg;

    localparam int WORD_NUM_BIT = 8;
    localparam int POS_NUM_BIT  = 4;
    localparam int POS_NUM      = 11;
    localparam int P_SIZE       = 32;

    localparam logic [WORD_NUM_BIT-1:0] MAX_WORD = WORD_NUM_BIT'(95);
    localparam logic [POS_NUM_BIT-1:0]  LAST_POS = POS_NUM_BIT'(POS_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } sweep_state_e;

    // True for the final POS tag of a word's sweep.
    function automatic logic is_last_pos(input logic [POS_NUM_BIT-1:0] pos);
        return pos == LAST_POS;
    endfunction

endpackage

// File: rtl/emission_out_reg.sv
// -----------------------------------------------------------------------------
// emission_out_reg
//   Single-entry valid/ready holding register for (pos, probability, last) beats.
//   The parent asserts load only when the register is empty or being drained
//   in the same cycle, so a held beat is never overwritten.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   load            capture in_* this cycle (register becomes/stays valid)
//   in_pos/in_p     beat POS index and probability to capture
//   in_last         beat is the final POS of the word
//   out_ready       downstream accepts the current beat
//   out_valid       register holds a beat
//   out_pos/out_p   held beat contents
//   out_last        held beat is the last of its word
// -----------------------------------------------------------------------------
module emission_out_reg #(
    parameter int POS_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [POS_W-1:0]  in_pos,
    input  logic [DATA_W-1:0] in_p,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [POS_W-1:0]  out_pos,
    output logic [DATA_W-1:0] out_p,
    output logic              out_last
);

    logic              valid_q, valid_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic [DATA_W-1:0] p_q,     p_d;
    logic              last_q,  last_d;

    // Load takes priority over drain; a drained-but-not-reloaded register goes
    // empty while keeping its last contents on the data lines.
    always_comb begin
        valid_d = valid_q;
        pos_d   = pos_q;
        p_d     = p_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            pos_d   = in_pos;
            p_d     = in_p;
            last_d  = in_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pos_q   <= '0;
            p_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pos_q   <= pos_d;
            p_q     <= p_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pos   = pos_q;
    assign out_p     = p_q;
    assign out_last  = last_q;

endmodule

// File: rtl/emission_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// emission_sweep_ctrl
//   Sequencer in front of the emission-probability table. Accepts one word
//   index per observation step, sweeps POS 0..POS_NUM-1 through the
//   (combinational) table and streams (pos, probability) beats downstream.
//   Optional feature macro: EMISS_RANGE_CHECK_EN -- rejects word_in >= MAX_WORD
//   with a one-cycle err pulse instead of sweeping it.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   word_in/word_valid    next observed word index, valid
//   word_ready            controller idle and able to accept a word
//   tbl_word/tbl_pos      table address
//   tbl_p                 table data for the current address (same cycle)
//   out_pos/out_p         current beat POS and emission probability
//   out_valid/out_ready   beat handshake
//   out_last              beat is POS_NUM-1 of this word
//   busy                  sweep in progress
//   err                   (EMISS_RANGE_CHECK_EN) out-of-range word rejected
// -----------------------------------------------------------------------------
module emission_sweep_ctrl
    import viterbi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_NUM_BIT-1:0] word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [WORD_NUM_BIT-1:0] tbl_word,
    output logic [POS_NUM_BIT-1:0]  tbl_pos,
    input  logic [P_SIZE-1:0]       tbl_p,
    output logic [POS_NUM_BIT-1:0]  out_pos,
    output logic [P_SIZE-1:0]       out_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
`ifdef EMISS_RANGE_CHECK_EN
    ,
    output logic                    err
`endif
);

    sweep_state_e            state_q, state_d;
    logic [WORD_NUM_BIT-1:0] tbl_word_q, tbl_word_d;
    logic [POS_NUM_BIT-1:0]  tbl_pos_q, tbl_pos_d;
    logic                    load;
`ifdef EMISS_RANGE_CHECK_EN
    logic                    err_q, err_d;
`endif

    // Next-state logic. The POS counter advances only when the output register
    // actually captures the current table read, so stalls never skip or repeat
    // a POS. The counter parks on the last POS rather than wrapping.
    always_comb begin
        state_d    = state_q;
        tbl_word_d = tbl_word_q;
        tbl_pos_d  = tbl_pos_q;
        load       = 1'b0;
`ifdef EMISS_RANGE_CHECK_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (word_valid) begin
`ifdef EMISS_RANGE_CHECK_EN
                    if (word_in >= MAX_WORD) begin
                        err_d = 1'b1;
                    end else begin
                        tbl_word_d = word_in;
                        tbl_pos_d  = '0;
                        state_d    = SWEEP;
                    end
`else
                    tbl_word_d = word_in;
                    tbl_pos_d  = '0;
                    state_d    = SWEEP;
`endif
                end
            end
            SWEEP: begin
                if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (is_last_pos(tbl_pos_q)) begin
                        state_d = DRAIN;
                    end else begin
                        tbl_pos_d = tbl_pos_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tbl_word_q <= '0;
            tbl_pos_q  <= '0;
        end else begin
            state_q    <= state_d;
            tbl_word_q <= tbl_word_d;
            tbl_pos_q  <= tbl_pos_d;
        end
    end

`ifdef EMISS_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    emission_out_reg #(
        .POS_W  (POS_NUM_BIT),
        .DATA_W (P_SIZE)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_pos    (tbl_pos_q),
        .in_p      (tbl_p),
        .in_last   (is_last_pos(tbl_pos_q)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pos   (out_pos),
        .out_p     (out_p),
        .out_last  (out_last)
    );

    assign word_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign tbl_word   = tbl_word_q;
    assign tbl_pos    = tbl_pos_q;

endmodule

// File: tb/tb_emission_sweep_ctrl.sv
module tb_emission_sweep_ctrl;
    import viterbi_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [WORD_NUM_BIT-1:0] word_in;
    logic                    word_valid;
    logic                    word_ready;
    logic [WORD_NUM_BIT-1:0] tbl_word;
    logic [POS_NUM_BIT-1:0]  tbl_pos;
    logic [P_SIZE-1:0]       tbl_p;
    logic [POS_NUM_BIT-1:0]  out_pos;
    logic [P_SIZE-1:0]       out_p;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
`ifdef EMISS_RANGE_CHECK_EN
    logic                    err;
`endif

    // Behavioural emission table, randomly filled.
    logic [P_SIZE-1:0] mem [0:255][0:15];
    assign tbl_p = mem[tbl_word][tbl_pos];

    typedef struct {
        logic [POS_NUM_BIT-1:0] pos;
        logic [P_SIZE-1:0]      p;
        logic                   last;
    } beat_t;

    beat_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    emission_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tbl_word   (tbl_word),
        .tbl_pos    (tbl_pos),
        .tbl_p      (tbl_p),
        .out_pos    (out_pos),
        .out_p      (out_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
`ifdef EMISS_RANGE_CHECK_EN
        ,
        .err        (err)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one word (caller is at a negedge with the controller idle).
    // mode 0: out_ready always 1; 1: random; 2: repeating 1,0,0,1.
    // While busy, word_valid stays high with junk words that must be ignored.
    // If chain is set, the next word is presented as the last beat handshakes.
    task automatic applyStimulus(input logic [WORD_NUM_BIT-1:0] w, input int mode,
                                 input bit chain, input logic [WORD_NUM_BIT-1:0] next_w);
        int  cyc;
        bit  seen_first;
        bit  last_hs;
        logic [3:0] pat;
        pat = 4'b1001;
        checkOutput("word_ready_before_accept", {31'd0, word_ready}, 32'd1);
        word_in    = w;
        word_valid = 1'b1;
        for (int k = 0; k < POS_NUM; k++) begin
            beat_t b;
            b.pos  = POS_NUM_BIT'(k);
            b.p    = mem[w][k];
            b.last = (k == POS_NUM - 1);
            exp_q.push_back(b);
        end
        @(negedge clk);
        word_in = WORD_NUM_BIT'($urandom_range(0, 94));
        checkOutput("first_cycle_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("first_cycle_busy", {31'd0, busy}, 32'd1);
        checkOutput("first_cycle_word_ready", {31'd0, word_ready}, 32'd0);
        checkOutput("first_cycle_tbl_word", {24'd0, tbl_word}, {24'd0, w});
        checkOutput("first_cycle_tbl_pos", {28'd0, tbl_pos}, 32'd0);
        cyc        = 0;
        seen_first = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = pat[cyc % 4];
            endcase
            checkOutput("busy_tbl_word", {24'd0, tbl_word}, {24'd0, w});
            if (out_valid) begin
                if (!seen_first) begin
                    checkOutput("first_beat_latency", cyc, 1);
                    seen_first = 1;
                end
                checkOutput("out_pos", {28'd0, out_pos}, {28'd0, exp_q[0].pos});
                checkOutput("out_p", out_p, exp_q[0].p);
                checkOutput("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                if (out_ready) begin
                    last_hs = exp_q[0].last;
                    void'(exp_q.pop_front());
                    if (last_hs) begin
                        word_valid = chain;
                        if (chain) word_in = next_w;
                    end
                end
            end else begin
                checkOutput("idle_out_last", {31'd0, out_last}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("beats_remaining", exp_q.size(), 0);
        exp_q.delete();
        if (mode == 0) checkOutput("sweep_cycles", cyc, POS_NUM + 1);
        checkOutput("after_word_ready", {31'd0, word_ready}, 32'd1);
        checkOutput("after_busy", {31'd0, busy}, 32'd0);
        checkOutput("after_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [WORD_NUM_BIT-1:0] w;
        logic [WORD_NUM_BIT-1:0] w2;
        int guard;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 16; j++)
                mem[i][j] = $urandom;

        rst        = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_word_ready", {31'd0, word_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_last", {31'd0, out_last}, 32'd0);
        checkOutput("reset_out_pos", {28'd0, out_pos}, 32'd0);
        checkOutput("reset_out_p", out_p, 32'd0);
        checkOutput("reset_tbl_word", {24'd0, tbl_word}, 32'd0);
        checkOutput("reset_tbl_pos", {28'd0, tbl_pos}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
`ifdef EMISS_RANGE_CHECK_EN
        checkOutput("reset_err", {31'd0, err}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] word 5, continuous ready");
        applyStimulus(8'd5, 0, 1'b0, 8'd0);

        $display("[TB] word 7, ready pattern 1,0,0,1");
        applyStimulus(8'd7, 2, 1'b0, 8'd0);

        $display("[TB] words 3 then 9 back-to-back");
        applyStimulus(8'd3, 0, 1'b1, 8'd9);
        applyStimulus(8'd9, 0, 1'b0, 8'd0);

        $display("[TB] reset mid-sweep at pos 4");
        w          = WORD_NUM_BIT'($urandom_range(0, 94));
        word_in    = w;
        word_valid = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        guard = 0;
        while (!(out_valid && out_pos == 4) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_pos4", guard < 50, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_word_ready", {31'd0, word_ready}, 32'd1);
        checkOutput("midreset_tbl_pos", {28'd0, tbl_pos}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_out_pos", {28'd0, out_pos}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(WORD_NUM_BIT'($urandom_range(0, 94)), 0, 1'b0, 8'd0);

        $display("[TB] randomized words and backpressure");
        for (int n = 0; n < 6; n++) begin
            w  = WORD_NUM_BIT'($urandom_range(0, 94));
            w2 = WORD_NUM_BIT'($urandom_range(0, 94));
            applyStimulus(w, 1, 1'b1, w2);
            applyStimulus(w2, 1, 1'b0, 8'd0);
        end

`ifdef EMISS_RANGE_CHECK_EN
        $display("[TB] range check: word 95 rejected, 94 swept");
        word_in    = 8'd95;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        checkOutput("err_pulse", {31'd0, err}, 32'd1);
        checkOutput("err_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("err_word_ready", {31'd0, word_ready}, 32'd1);
        checkOutput("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("err_one_cycle", {31'd0, err}, 32'd0);
        checkOutput("err_no_beat", {31'd0, out_valid}, 32'd0);
        applyStimulus(8'd94, 0, 1'b0, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
